tap_controller: RTL

- IEEE 1149.1 TAP state machine plus instruction-register shift/update path for the JTAG block.
- Sequences all TAP operations from TMS and drives the DR-path strobes.
- Shifts instructions in from TDI and presents the latched instruction on LATCH_IR, which feeds the instruction state decoder.

---
 rtl/tap_controller_if.sv | 34 +++
 rtl/tap_controller.sv | 100 ++++++++++
 2 files changed

// File: rtl/tap_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : tap_controller_if
// Description : TAP mode/data inputs and the decoded strobes plus IR outputs
//               that feed the instruction decoder and DR-path logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface tap_controller_if #(
    parameter int IR_WIDTH = 4
);
    logic                TMS;
    logic                TDI;
    logic [IR_WIDTH-1:0] LATCH_IR;
    logic                TDO_IR;
    logic                TDO_SEL_IR;
    logic                CAPTURE_DR;
    logic                SHIFT_DR;
    logic                UPDATE_DR;
    logic                RUN_IDLE;
    logic                TAP_RESET;

    modport master (
        output TMS, TDI,
        input  LATCH_IR, TDO_IR, TDO_SEL_IR, CAPTURE_DR, SHIFT_DR,
               UPDATE_DR, RUN_IDLE, TAP_RESET
    );

    modport slave (
        input  TMS, TDI,
        output LATCH_IR, TDO_IR, TDO_SEL_IR, CAPTURE_DR, SHIFT_DR,
               UPDATE_DR, RUN_IDLE, TAP_RESET
    );
endinterface
`default_nettype wire

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tap_controller
// Description : IEEE 1149.1 TAP state machine with instruction register
//               capture/shift/update path and decoded DR strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_controller #(
    parameter int                  IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(7)
) (
    input  wire logic          TCK,
    input  wire logic          RST,
    tap_controller_if.slave    bus
);

    typedef logic [3:0] state_t;

    localparam state_t S_TLR      = 4'd0;
    localparam state_t S_RTI      = 4'd1;
    localparam state_t S_SEL_DR   = 4'd2;
    localparam state_t S_CAP_DR   = 4'd3;
    localparam state_t S_SH_DR    = 4'd4;
    localparam state_t S_EX1_DR   = 4'd5;
    localparam state_t S_PAUSE_DR = 4'd6;
    localparam state_t S_EX2_DR   = 4'd7;
    localparam state_t S_UPD_DR   = 4'd8;
    localparam state_t S_SEL_IR   = 4'd9;
    localparam state_t S_CAP_IR   = 4'd10;
    localparam state_t S_SH_IR    = 4'd11;
    localparam state_t S_EX1_IR   = 4'd12;
    localparam state_t S_PAUSE_IR = 4'd13;
    localparam state_t S_EX2_IR   = 4'd14;
    localparam state_t S_UPD_IR   = 4'd15;

    state_t              r_state;
    state_t              w_next;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_latch_ir;

    always_ff @(posedge TCK) begin
        if (RST) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:      w_next = bus.TMS ? S_TLR      : S_RTI;
            S_RTI:      w_next = bus.TMS ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   w_next = bus.TMS ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   w_next = bus.TMS ? S_EX1_DR   : S_SH_DR;
            S_SH_DR:    w_next = bus.TMS ? S_EX1_DR   : S_SH_DR;
            S_EX1_DR:   w_next = bus.TMS ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: w_next = bus.TMS ? S_EX2_DR   : S_PAUSE_DR;
            S_EX2_DR:   w_next = bus.TMS ? S_UPD_DR   : S_SH_DR;
            S_UPD_DR:   w_next = bus.TMS ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   w_next = bus.TMS ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   w_next = bus.TMS ? S_EX1_IR   : S_SH_IR;
            S_SH_IR:    w_next = bus.TMS ? S_EX1_IR   : S_SH_IR;
            S_EX1_IR:   w_next = bus.TMS ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: w_next = bus.TMS ? S_EX2_IR   : S_PAUSE_IR;
            S_EX2_IR:   w_next = bus.TMS ? S_UPD_IR   : S_SH_IR;
            S_UPD_IR:   w_next = bus.TMS ? S_SEL_DR   : S_RTI;
            default:    w_next = S_TLR;
        endcase
    end

    // IR actions key off the state being left, so a new instruction appears
    // together with RTI/Select-DR.
    always_ff @(posedge TCK) begin
        if (RST) begin
            r_ir_shift <= IR_CAPTURE;
            r_latch_ir <= IR_RESET;
        end else begin
            case (r_state)
                S_CAP_IR: r_ir_shift <= IR_CAPTURE;
                S_SH_IR:  r_ir_shift <= {bus.TDI, r_ir_shift[IR_WIDTH-1:1]};
                S_UPD_IR: r_latch_ir <= r_ir_shift;
                S_TLR:    r_latch_ir <= IR_RESET;
                default:  ;
            endcase
        end
    end

    assign bus.LATCH_IR   = r_latch_ir;
    assign bus.TDO_IR     = r_ir_shift[0];
    assign bus.TDO_SEL_IR = (r_state == S_SH_IR);
    assign bus.CAPTURE_DR = (r_state == S_CAP_DR);
    assign bus.SHIFT_DR   = (r_state == S_SH_DR);
    assign bus.UPDATE_DR  = (r_state == S_UPD_DR);
    assign bus.RUN_IDLE   = (r_state == S_RTI);
    assign bus.TAP_RESET  = (r_state == S_TLR);

endmodule
`default_nettype wire
